ifsram_rd: RTL and testbench

IFSRAM_RD -- requirements
Module: ifsram_rd

---
 rtl/ifsram_pkg.sv | 36 +++
 rtl/ifsram_rd_fifo2.sv | 68 ++++++
 rtl/ifsram_rd.sv | 190 +++++++++++++++++++
 tb/tb_ifsram_rd.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifsram_pkg.sv
// ---------------------------------------------------------------------------
// ifsram_pkg
// Shared definitions for the input-feature-map SRAM read window:
//   - state_t      : control FSM state encodings
//   - CONV_*       : cfg_conv_switch codes
//   - ROWS_*       : number of rows read per window for each code
//   - rows_for()   : maps a cfg_conv_switch value to a row count
// ---------------------------------------------------------------------------
package ifsram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] CONV_3X3 = 3'd2;
   localparam logic [2:0] CONV_5X5 = 3'd3;

   localparam logic [2:0] ROWS_3X3 = 3'd3;
   localparam logic [2:0] ROWS_5X5 = 3'd5;
   localparam logic [2:0] ROWS_1X1 = 3'd1;

   // Any code other than the two kernel sizes reads a single row.
   function automatic logic [2:0] rows_for(input logic [2:0] conv);
      logic [2:0] rows;
      case (conv)
         CONV_3X3: rows = ROWS_3X3;
         CONV_5X5: rows = ROWS_5X5;
         default:  rows = ROWS_1X1;
      endcase
      return rows;
   endfunction

endpackage

// File: rtl/ifsram_rd_fifo2.sv
// ---------------------------------------------------------------------------
// ifsram_rd_fifo2
// Two-entry first-word-fall-through FIFO holding SRAM words on their way to
// the output stream. A push and a pop in the same cycle both take effect.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, din    : write strobe and data
//   pop          : removes the head entry
//   dout         : current head (valid while !empty)
//   count        : occupancy 0..2
//   empty, full  : occupancy flags
// ---------------------------------------------------------------------------
module ifsram_rd_fifo2 #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == 2'd0);
   assign full  = (count_q == 2'd2);

endmodule

// File: rtl/ifsram_rd.sv
// ---------------------------------------------------------------------------
// ifsram_rd
// Reads a window of 1, 3 or 5 rows of (cfg_cnt_step+1) words each from the
// input-feature-map SRAM and streams the words out with valid/ready.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   if_rd_start           : one-cycle window request (honoured only in IDLE)
//   if_rd_busy/done       : window in progress / one-cycle completion pulse
//   cfg_conv_switch       : 2 -> 3 rows, 3 -> 5 rows, else 1 row
//   cfg_rd_list_0..4      : per-row base addresses
//   cfg_cnt_step          : words per row minus one
//   rdb_cen/wen/addr/q    : SRAM read port (1-cycle read latency)
//   rd_data/valid/ready   : output stream
// ---------------------------------------------------------------------------
module ifsram_rd
   import ifsram_pkg::*;
#(
   parameter int TBITS              = 64,
   parameter int IFMAP_SRAM_ADDBITS = 11,
   parameter int CNTSTP_WIDTH       = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          if_rd_start,
   output logic                          if_rd_busy,
   output logic                          if_rd_done,
   input  logic [2:0]                    cfg_conv_switch,
   input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_rd_list_0,
   input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_rd_list_1,
   input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_rd_list_2,
   input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_rd_list_3,
   input  logic [IFMAP_SRAM_ADDBITS-1:0] cfg_rd_list_4,
   input  logic [CNTSTP_WIDTH-1:0]       cfg_cnt_step,
   output logic                          rdb_cen,
   output logic                          rdb_wen,
   output logic [IFMAP_SRAM_ADDBITS-1:0] rdb_addr,
   input  logic [TBITS-1:0]              rdb_q,
   output logic [TBITS-1:0]              rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready
);

   localparam int AW = IFMAP_SRAM_ADDBITS;

   state_t                  state_q, state_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [2:0]              rows_q, rows_d;
   logic [2:0]              r_q, r_d;
   logic [CNTSTP_WIDTH-1:0] step_q, step_d;
   logic [CNTSTP_WIDTH-1:0] c_q, c_d;
   logic [AW-1:0]           list_q [5];
   logic [AW-1:0]           list_d [5];
   logic                    inflight_q, inflight_d;

   logic [AW-1:0]           cfg_list [5];
   logic [AW-1:0]           cur_base;
   logic [1:0]              fifo_count;
   logic                    fifo_empty, fifo_full;
   logic                    push, pop, issue;
   logic [2:0]              occ;
   logic                    last_col, last_row;

   assign cfg_list[0] = cfg_rd_list_0;
   assign cfg_list[1] = cfg_rd_list_1;
   assign cfg_list[2] = cfg_rd_list_2;
   assign cfg_list[3] = cfg_rd_list_3;
   assign cfg_list[4] = cfg_rd_list_4;

   assign rd_valid = ~fifo_empty;
   assign pop      = rd_valid & rd_ready;

   // Words already committed to the FIFO: stored + in flight, less the one
   // leaving this cycle. Keeping this below 2 means the word returned by a
   // read issued now always finds a free slot.
   assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue = (state_q == ST_READ) && (occ < 3'd2);

   // The full guard never blocks a real word given the issue rule; it keeps
   // the FIFO safe regardless of what the SRAM returns.
   assign push = inflight_q & (~fifo_full | pop);

   assign last_col = (c_q == step_q);
   assign last_row = (r_q == rows_q - 3'd1);

   always_comb begin
      cur_base = '0;
      for (int i = 0; i < 5; i++) begin
         if (r_q == 3'(i)) begin
            cur_base = list_q[i];
         end
      end
   end

   // Base + column offset wraps naturally at the address width.
   assign rdb_addr = cur_base + AW'(c_q);
   assign rdb_cen  = ~issue;
   assign rdb_wen  = 1'b1;

   always_comb begin
      state_d    = state_q;
      rows_d     = rows_q;
      step_d     = step_q;
      list_d     = list_q;
      r_d        = r_q;
      c_d        = c_q;
      inflight_d = issue;
      case (state_q)
         ST_IDLE: begin
            if (if_rd_start) begin
               state_d = ST_READ;
               rows_d  = rows_for(cfg_conv_switch);
               step_d  = cfg_cnt_step;
               list_d  = cfg_list;
               r_d     = 3'd0;
               c_d     = '0;
            end
         end
         ST_READ: begin
            if (issue) begin
               if (last_col) begin
                  c_d = '0;
                  r_d = r_q + 3'd1;
               end else begin
                  c_d = c_q + 1'b1;
               end
               if (last_col && last_row) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Leave once the FIFO will be empty after this cycle's pop, so
            // done follows the last beat by exactly one cycle.
            if (!inflight_q && (fifo_count == {1'b0, pop})) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rows_q     <= 3'd0;
         step_q     <= '0;
         r_q        <= 3'd0;
         c_q        <= '0;
         inflight_q <= 1'b0;
         for (int i = 0; i < 5; i++) begin
            list_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rows_q     <= rows_d;
         step_q     <= step_d;
         r_q        <= r_d;
         c_q        <= c_d;
         inflight_q <= inflight_d;
         list_q     <= list_d;
      end
   end

   assign if_rd_busy = busy_q;
   assign if_rd_done = done_q;

   ifsram_rd_fifo2 #(
      .WIDTH (TBITS)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .pop   (pop),
      .din   (rdb_q),
      .dout  (rd_data),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_ifsram_rd.sv
// ---------------------------------------------------------------------------
// tb_ifsram_rd
// Directed bench for ifsram_rd: a behavioural SRAM returns a word tagged with
// its address one cycle after each read; a negedge monitor logs issued
// addresses, transferred beats and done pulses and checks stall stability and
// the occupancy rule on every read. Windows are compared with hand-written
// address lists.
// ---------------------------------------------------------------------------
module tb_ifsram_rd;

   localparam int TB = 64;
   localparam int AW = 11;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          if_rd_start = 1'b0;
   logic          if_rd_busy, if_rd_done;
   logic [2:0]    cfg_conv_switch = 3'd0;
   logic [AW-1:0] cfg_rd_list_0 = '0, cfg_rd_list_1 = '0, cfg_rd_list_2 = '0;
   logic [AW-1:0] cfg_rd_list_3 = '0, cfg_rd_list_4 = '0;
   logic [CW-1:0] cfg_cnt_step = '0;
   logic          rdb_cen, rdb_wen;
   logic [AW-1:0] rdb_addr;
   logic [TB-1:0] rdb_q = '0;
   logic [TB-1:0] rd_data;
   logic          rd_valid;
   logic          rd_ready = 1'b1;

   ifsram_rd #(
      .TBITS              (TB),
      .IFMAP_SRAM_ADDBITS (AW),
      .CNTSTP_WIDTH       (CW)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .if_rd_start     (if_rd_start),
      .if_rd_busy      (if_rd_busy),
      .if_rd_done      (if_rd_done),
      .cfg_conv_switch (cfg_conv_switch),
      .cfg_rd_list_0   (cfg_rd_list_0),
      .cfg_rd_list_1   (cfg_rd_list_1),
      .cfg_rd_list_2   (cfg_rd_list_2),
      .cfg_rd_list_3   (cfg_rd_list_3),
      .cfg_rd_list_4   (cfg_rd_list_4),
      .cfg_cnt_step    (cfg_cnt_step),
      .rdb_cen         (rdb_cen),
      .rdb_wen         (rdb_wen),
      .rdb_addr        (rdb_addr),
      .rdb_q           (rdb_q),
      .rd_data         (rd_data),
      .rd_valid        (rd_valid),
      .rd_ready        (rd_ready)
   );

   always #5 clk = ~clk;

   // SRAM model: data tagged with the address, one cycle read latency.
   always @(posedge clk) begin
      if (!rdb_cen) rdb_q <= {32'hDA7A_0000, 21'd0, rdb_addr};
   end

   int errors = 0;
   int checks = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // ---------------- monitor ----------------
   logic [AW-1:0] issued[$];
   logic [TB-1:0] beats[$];
   logic [AW-1:0] exp_addr[$];
   int            done_cnt = 0;
   int            cyc = 0;
   int            last_beat_cyc = -1;
   int            done_cyc = -1;
   int            outstanding = 0;
   int            mon_pop;
   bit            prev_stall = 0;
   logic [TB-1:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         outstanding = 0;
         prev_stall  = 0;
      end else begin
         mon_pop = (rd_valid && rd_ready) ? 1 : 0;
         if (prev_stall) begin
            check_eq("stall_valid", rd_valid, 1);
            check_eq("stall_data", rd_data, prev_data);
         end
         if (!rdb_cen) begin
            check_eq("cen_occupancy", ((outstanding - mon_pop) < 2) ? 1 : 0, 1);
            check_eq("wen_high", rdb_wen, 1);
            issued.push_back(rdb_addr);
         end
         if (mon_pop == 1) begin
            beats.push_back(rd_data);
            last_beat_cyc = cyc;
         end
         if (if_rd_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         outstanding = outstanding + (rdb_cen ? 0 : 1) - mon_pop;
         prev_stall  = rd_valid && !rd_ready;
         prev_data   = rd_data;
      end
   end

   task automatic check_reset_outputs(input string name);
      check_eq({name, "_cen"},   rdb_cen, 1);
      check_eq({name, "_wen"},   rdb_wen, 1);
      check_eq({name, "_addr"},  rdb_addr, 0);
      check_eq({name, "_valid"}, rd_valid, 0);
      check_eq({name, "_data"},  rd_data, 0);
      check_eq({name, "_busy"},  if_rd_busy, 0);
      check_eq({name, "_done"},  if_rd_done, 0);
   endtask

   // Pulses start (caller is just after a rising edge), then runs the window
   // to completion and compares against exp_addr.
   task automatic run_window(input string name, input logic [2:0] conv, input logic [CW-1:0] step,
                             input logic [AW-1:0] l0, input logic [AW-1:0] l1, input logic [AW-1:0] l2,
                             input logic [AW-1:0] l3, input logic [AW-1:0] l4,
                             input bit toggle, input bit restart);
      bit got_done;
      issued.delete();
      beats.delete();
      done_cnt = 0; done_cyc = -1; last_beat_cyc = -1;
      cfg_conv_switch = conv; cfg_cnt_step = step;
      cfg_rd_list_0 = l0; cfg_rd_list_1 = l1; cfg_rd_list_2 = l2;
      cfg_rd_list_3 = l3; cfg_rd_list_4 = l4;
      if_rd_start = 1'b1;
      @(posedge clk); #1;
      if_rd_start = 1'b0;
      // Scramble config: the window must use the values sampled at start.
      cfg_conv_switch = 3'd3; cfg_cnt_step = '1;
      cfg_rd_list_0 = 11'h5A5; cfg_rd_list_1 = 11'h3C3;
      check_eq({name, "_busy"}, if_rd_busy, 1);
      check_eq({name, "_valid_e1"}, rd_valid, 0);
      @(posedge clk); #1;
      check_eq({name, "_valid_e2"}, rd_valid, 0);
      @(posedge clk); #1;
      check_eq({name, "_valid_e3"}, rd_valid, 1);
      got_done = (done_cnt > 0);
      for (int n = 0; n < 400 && !got_done; n++) begin
         @(posedge clk); #1;
         if (toggle) rd_ready = ~rd_ready;
         if_rd_start = (restart && n == 2);
         if (done_cnt > 0) got_done = 1;
      end
      if_rd_start = 1'b0;
      check_eq({name, "_timeout"}, got_done, 1);
      repeat (4) @(posedge clk);
      #1;
      rd_ready = 1'b1;
      check_eq({name, "_done_cnt"}, done_cnt, 1);
      check_eq({name, "_idle_busy"}, if_rd_busy, 0);
      check_eq({name, "_n_reads"}, issued.size(), exp_addr.size());
      check_eq({name, "_n_beats"}, beats.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size(); i++) begin
         if (i < issued.size()) check_eq($sformatf("%s_addr%0d", name, i), issued[i], exp_addr[i]);
         if (i < beats.size())
            check_eq($sformatf("%s_beat%0d", name, i), beats[i], {32'hDA7A_0000, 21'd0, exp_addr[i]});
      end
      if (!toggle) check_eq({name, "_done_lat"}, done_cyc - last_beat_cyc, 1);
   endtask

   initial begin
      bit seen;
      // Reset from time zero.
      #1;
      check_reset_outputs("por");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      // 3x3 full throughput.
      exp_addr = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd24, 11'd25, 11'd26, 11'd27,
                   11'd48, 11'd49, 11'd50, 11'd51};
      run_window("c3x3", 3'd2, 3'd3, 11'd0, 11'd24, 11'd48, 11'd0, 11'd0, 1'b0, 1'b0);

      // 5x5, eight words per row.
      exp_addr.delete();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 8; c++)
            exp_addr.push_back(AW'(r * 20 + c));
      run_window("c5x5", 3'd3, 3'd7, 11'd0, 11'd20, 11'd40, 11'd60, 11'd80, 1'b0, 1'b0);
      check_eq("c5x5_last_addr", (issued.size() > 0) ? issued[issued.size()-1] : 11'h7FF, 87);

      // Backpressure: rd_ready toggles every cycle.
      exp_addr = '{11'd100, 11'd101, 11'd102, 11'd200, 11'd201, 11'd202,
                   11'd300, 11'd301, 11'd302};
      run_window("bp", 3'd2, 3'd2, 11'd100, 11'd200, 11'd300, 11'd7, 11'd9, 1'b1, 1'b0);

      // Address wrap, single row.
      exp_addr = '{11'd2046, 11'd2047, 11'd0, 11'd1};
      run_window("wrap", 3'd0, 3'd3, 11'd2046, 11'd500, 11'd600, 11'd700, 11'd800, 1'b0, 1'b0);

      // Single beat window with an unlisted conv code.
      exp_addr = '{11'd5};
      run_window("one", 3'd7, 3'd0, 11'd5, 11'd50, 11'd60, 11'd70, 11'd90, 1'b0, 1'b0);

      // Start re-asserted during READ is ignored.
      exp_addr = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd24, 11'd25, 11'd26, 11'd27,
                   11'd48, 11'd49, 11'd50, 11'd51};
      run_window("restart", 3'd2, 3'd3, 11'd0, 11'd24, 11'd48, 11'd0, 11'd0, 1'b0, 1'b1);

      // Reset after beat 5.
      issued.delete(); beats.delete(); done_cnt = 0;
      cfg_conv_switch = 3'd2; cfg_cnt_step = 3'd3;
      cfg_rd_list_0 = 11'd0; cfg_rd_list_1 = 11'd24; cfg_rd_list_2 = 11'd48;
      if_rd_start = 1'b1;
      @(posedge clk); #1;
      if_rd_start = 1'b0;
      seen = 0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(posedge clk); #1;
         if (beats.size() >= 5) seen = 1;
      end
      check_eq("rst_mid_reach5", seen, 1);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      done_cnt = 0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("rst_mid_no_done", done_cnt, 0);
      check_eq("rst_mid_idle_busy", if_rd_busy, 0);
      check_eq("rst_mid_discard", rd_valid, 0);
      run_window("after_rst", 3'd2, 3'd3, 11'd0, 11'd24, 11'd48, 11'd0, 11'd0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
